// File: rtl/fp32_divider_seq.sv
// Multi-cycle IEEE-754 single-precision divider (FDIV.S), restoring division, RNE rounding.
// Subnormal operands are read as zero and tiny results are flushed to signed zero.
module fp32_divider_seq #(
   parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   localparam logic [4:0] FLAG_NV = 5'b10000;
   localparam logic [4:0] FLAG_DZ = 5'b01000;
   localparam logic [4:0] FLAG_OF = 5'b00100;
   localparam logic [4:0] FLAG_UF = 5'b00010;
   localparam logic [4:0] FLAG_NX = 5'b00001;

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIV, S_ROUND, S_DONE} state_t;

   state_t state, state_nxt;

   logic [31:0]       a_q, b_q;
   logic              sign_q;
   logic signed [9:0] exp_q;
   logic [23:0]       mb_q;
   logic [24:0]       rem_q;
   logic [26:0]       q_q;
   logic [4:0]        cnt_q;

   // operand classification of the captured operands
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic        is_special, sign_c;

   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign fa     = a_q[22:0];
   assign fb     = b_q[22:0];
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_inf  = (ea == 8'hFF) && (fa == '0);
   assign b_inf  = (eb == 8'hFF) && (fb == '0);
   assign a_nan  = (ea == 8'hFF) && (fa != '0);
   assign b_nan  = (eb == 8'hFF) && (fb != '0);
   assign a_snan = a_nan && !fa[22];
   assign b_snan = b_nan && !fb[22];
   assign sign_c = a_q[31] ^ b_q[31];
   assign is_special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;

   logic [31:0] spec_res;
   logic [4:0]  spec_flags;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      spec_res   = CANON_NAN;
      spec_flags = '0;
      if (a_nan || b_nan) begin
         spec_flags = (a_snan || b_snan) ? FLAG_NV : '0;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_flags = FLAG_NV;
      end else if (a_inf) begin
         spec_res = {sign_c, 8'hFF, 23'd0};
      end else if (b_inf || a_zero) begin
         spec_res = {sign_c, 31'd0};
      end else begin
         spec_res   = {sign_c, 8'hFF, 23'd0};
         spec_flags = FLAG_DZ;
      end
   end

   // one restoring-division step
   logic [24:0] diff;
   logic        ge;
   assign diff = rem_q - {1'b0, mb_q};
   assign ge   = (rem_q >= {1'b0, mb_q});

   // normalise, round to nearest even, range check
   logic [23:0]       mant;
   logic              guard, sticky, inc;
   logic signed [9:0] e_adj, e_fin;
   logic [24:0]       mant_r;
   logic [22:0]       frac_f;
   logic [31:0]       rnd_res;
   logic [4:0]        rnd_flags;
   logic              unused_bits;

   always_comb begin
      if (q_q[26]) begin
         mant   = q_q[26:3];
         guard  = q_q[2];
         sticky = (|q_q[1:0]) | (|rem_q);
         e_adj  = exp_q;
      end else begin
         mant   = q_q[25:2];
         guard  = q_q[1];
         sticky = q_q[0] | (|rem_q);
         e_adj  = exp_q - 10'sd1;
      end
      inc    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, inc};
      frac_f = mant_r[24] ? 23'd0 : mant_r[22:0];
      e_fin  = mant_r[24] ? e_adj + 10'sd1 : e_adj;
      if (e_fin >= 10'sd255) begin
         rnd_res   = {sign_q, 8'hFF, 23'd0};
         rnd_flags = FLAG_OF | FLAG_NX;
      end else if (e_fin <= 10'sd0) begin
         rnd_res   = {sign_q, 31'd0};
         rnd_flags = FLAG_UF | FLAG_NX;
      end else begin
         rnd_res   = {sign_q, e_fin[7:0], frac_f};
         rnd_flags = (guard | sticky) ? FLAG_NX : '0;
      end
   end

   assign unused_bits = ^{mant_r[23], diff[24]};

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_UNPACK;
         S_UNPACK: begin
            busy      = 1'b1;
            state_nxt = is_special ? S_DONE : S_DIV;
         end
         S_DIV: begin
            busy = 1'b1;
            if (cnt_q == 5'd26) state_nxt = S_ROUND;
         end
         S_ROUND: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: only the architecturally visible result/flags are reset; datapath registers are
   // always reloaded before use, so resetting them would add cost without changing behaviour.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               a_q <= op_a;
               b_q <= op_b;
            end
            S_UNPACK: begin
               sign_q <= sign_c;
               exp_q  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
               rem_q  <= {2'b01, fa};
               mb_q   <= {1'b1, fb};
               q_q    <= '0;
               cnt_q  <= '0;
               if (is_special) begin
                  result <= spec_res;
                  flags  <= spec_flags;
               end
            end
            S_DIV: begin
               rem_q <= ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
               q_q   <= {q_q[25:0], ge};
               cnt_q <= cnt_q + 5'd1;
            end
            S_ROUND: begin
               result <= rnd_res;
               flags  <= rnd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Scoreboard bench for fp32_divider_seq: directed spec vectors plus random operands
// checked against an integer-arithmetic reference model of FP32 division.
module tb_fp32_divider_seq;

   logic        clk, rst, start;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  flags;

   int tests = 0;
   int fails = 0;
   logic [36:0] sb_q[$];
   logic [31:0] last_res;

   localparam logic [31:0] NAN = 32'h7FC0_0000;

   fp32_divider_seq dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: returns {flags, result}
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
      int          ea, eb, e;
      logic [22:0] fa, fb;
      logic        s, az, bz, ainf, binf, anan, bnan, snan, g, st;
      longint      ma, mb, num, qq, rr, mant;
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      fa = a[22:0];        fb = b[22:0];
      s    = a[31] ^ b[31];
      az   = (ea == 0);    bz   = (eb == 0);
      ainf = (ea == 255) && (fa == 0);
      binf = (eb == 255) && (fb == 0);
      anan = (ea == 255) && (fa != 0);
      bnan = (eb == 255) && (fb != 0);
      snan = (anan && !fa[22]) || (bnan && !fb[22]);
      if (anan || bnan) return {(snan ? 5'b10000 : 5'b00000), NAN};
      if ((az && bz) || (ainf && binf)) return {5'b10000, NAN};
      if (ainf) return {5'b00000, s, 8'hFF, 23'd0};
      if (binf || az) return {5'b00000, s, 31'd0};
      if (bz) return {5'b01000, s, 8'hFF, 23'd0};
      ma = longint'({1'b1, fa});
      mb = longint'({1'b1, fb});
      e  = ea - eb + 127;
      if (ma < mb) begin
         ma = ma * 2;
         e  = e - 1;
      end
      num  = ma << 25;
      qq   = num / mb;
      rr   = num % mb;
      mant = qq >> 2;
      g    = qq[1];
      st   = qq[0] || (rr != 0);
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (longint'(1) << 24)) begin
         mant = 64'h80_0000;
         e    = e + 1;
      end
      if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {5'b00011, s, 31'd0};
      return {4'b0000, g | st, s, e[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int unsigned k;
      logic [7:0]  e;
      logic [22:0] f;
      k = $urandom_range(0, 19);
      f = 23'($urandom);
      case (k)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; f = '0; end
         2:       begin e = 8'hFF; if (f == '0) f = 23'd1; end
         3:       e = 8'($urandom_range(1, 254));
         4:       begin e = 8'($urandom_range(110, 144)); f = '0; end
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, f};
   endfunction

   // monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [36:0] exp_v;
            exp_v = sb_q.pop_front();
            check("result_flags", {27'd0, flags, result}, {27'd0, exp_v});
         end
      end
   end

   // one operation; optionally re-pulses start mid-division with other operands
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [36:0] exp_v,
                         input bit glitch);
      int lat, exp_lat;
      bit busy_ok;
      @(negedge clk);
      check("hold_result", {32'd0, result}, {32'd0, last_res});
      op_a = a; op_b = b; start = 1'b1;
      sb_q.push_back(exp_v);
      exp_lat = (a[30:23] == 8'h00 || a[30:23] == 8'hFF ||
                 b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 2 : 30;
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom;
      lat = 1; busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         start = (glitch && lat == 10);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (!done) begin
         check("timeout", 64'd0, 64'd1);
         void'(sb_q.pop_front());
      end else begin
         check("latency", 64'(lat), 64'(exp_lat));
         check("busy_during_op", 64'(busy_ok), 64'd1);
         check("busy_in_done", 64'(busy), 64'd0);
      end
      last_res = exp_v[31:0];
   endtask

   logic [31:0] da[8] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                          32'h7F800001, 32'h7F000000, 32'h00800000, 32'hC0C00000};
   logic [31:0] db[8] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                          32'h3F800000, 32'h3E800000, 32'h40000000, 32'h40000000};
   logic [36:0] dx[8] = '{{5'b00000, 32'h40400000}, {5'b00001, 32'h3EAAAAAB},
                          {5'b01000, 32'h7F800000}, {5'b10000, 32'h7FC00000},
                          {5'b10000, 32'h7FC00000}, {5'b00101, 32'h7F800000},
                          {5'b00011, 32'h00000000}, {5'b00000, 32'hC0400000}};

   initial begin
      bit saw_done;
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; last_res = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_op(da[i], db[i], dx[i], 1'b0);

      // start re-pulsed at cycle 10 must be ignored
      run_op(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000}, 1'b1);

      // reset in cycle 15 aborts the division
      @(negedge clk);
      op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", {32'd0, result}, 64'd0);
      check("abort_flags", 64'(flags), 64'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("no_done_after_abort", 64'(saw_done), 64'd0);
      last_res = '0;
      run_op(32'h3F800000, 32'h40400000, {5'b00001, 32'h3EAAAAAB}, 1'b0);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a, b;
         a = rand_fp();
         b = rand_fp();
         run_op(a, b, model(a, b), 1'b0);
      end

      @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
